// File: rtl/slot_arb_pkg.sv
// Shared definitions for the slot write arbiter: FSM state encoding,
// header byte constant and default parameter values.
package slot_arb_pkg;

    localparam int DEF_NUM_SLOTS     = 4;
    localparam int DEF_MAX_MSG_BYTES = 16;
    localparam int DEF_ADDR_W        = 11;

    localparam logic [7:0] HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Header byte tags the message with the granted slot number.
    function automatic logic [7:0] hdr_byte(input logic [3:0] slot);
        return HDR_BASE | {4'h0, slot};
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: returns the first requesting slot strictly after
// i_last_grant, wrapping from NUM_SLOTS-1 back to 0.
module rr_select
    import slot_arb_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_found
);

    int               w_cand;
    logic [IDX_W-1:0] w_idx;

    // Scan slots last_grant+1 .. last_grant+NUM_SLOTS, keep the first hit.
    always_comb begin
        o_grant = i_last_grant;
        o_found = 1'b0;
        w_cand  = 0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            w_cand = int'(i_last_grant) + i;
            if (w_cand >= NUM_SLOTS) begin
                w_cand = w_cand - NUM_SLOTS;
            end
            w_idx = IDX_W'(w_cand);
            if (!o_found && i_req[w_idx]) begin
                o_found = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/slot_write_arbiter.sv
// Slot write arbiter: serialises per-slot byte messages into one shared FIFO.
// A slot is granted only when the FIFO has room for a whole worst-case
// message, so a granted message never has to wait on FIFO space.
// Optional feature macro: SLOT_ARB_HEADER_EN -- when defined, each message
// is preceded by a header byte 8'hA0 | slot.
//
//   state  | meaning
//   IDLE   | waiting for a request and enough FIFO space
//   HEADER | writing the header byte for the granted slot
//   DATA   | forwarding payload bytes from the granted slot
module slot_write_arbiter
    import slot_arb_pkg::*;
#(
    parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
    parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SLOTS-1:0]   req_valid,
    input  logic [8*NUM_SLOTS-1:0] req_data,
    input  logic [NUM_SLOTS-1:0]   req_last,
    output logic [NUM_SLOTS-1:0]   req_ready,
    output logic [7:0]             fifo_data,
    output logic                   fifo_write,
    input  logic [ADDR_W-1:0]      fifo_addr_in,
    input  logic [ADDR_W-1:0]      fifo_addr_out,
    output logic                   grant_active,
    output logic                   trunc_err
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;

`ifdef SLOT_ARB_HEADER_EN
    localparam int NEED_BYTES = MAX_MSG_BYTES + 1;
`else
    localparam int NEED_BYTES = MAX_MSG_BYTES;
`endif
    localparam logic [ADDR_W:0] NEED_V = (ADDR_W+1)'(NEED_BYTES);

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trunc_err;
    logic             r_fifo_write;
    logic [7:0]       r_fifo_data;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] w_last_grant_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_trunc_nxt;
    logic             w_wr_nxt;
    logic [7:0]       w_data_nxt;

    logic [ADDR_W-1:0] w_used;
    logic [ADDR_W-1:0] w_free;
    logic              w_space_ok;
    logic [IDX_W-1:0]  w_sel_grant;
    logic              w_found;
    logic              w_cur_valid;
    logic              w_cur_last;
    logic [7:0]        w_cur_data;

    // free = depth - 1 - used, which is simply the bitwise inverse of used.
    assign w_used     = fifo_addr_in - fifo_addr_out;
    assign w_free     = ~w_used;
    assign w_space_ok = ({1'b0, w_free} >= NEED_V);

    rr_select #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_sel_grant),
        .o_found      (w_found)
    );

    // Mux out the granted slot's byte stream.
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = 8'h00;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_cur_valid = req_valid[i];
                w_cur_last  = req_last[i];
                w_cur_data  = req_data[8*i +: 8];
            end
        end
    end

    // Ready goes only to the granted slot in DATA, regardless of its valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            req_ready[i] = (r_state == ST_DATA) && (r_grant == IDX_W'(i));
        end
    end

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_trunc_nxt      = r_trunc_err;
        w_wr_nxt         = 1'b0;
        w_data_nxt       = r_fifo_data;
        case (r_state)
            ST_IDLE: begin
                if (w_found && w_space_ok) begin
                    w_grant_nxt = w_sel_grant;
                    w_cnt_nxt   = '0;
`ifdef SLOT_ARB_HEADER_EN
                    w_state_nxt = ST_HEADER;
`else
                    w_state_nxt = ST_DATA;
`endif
                end
            end
            ST_HEADER: begin
                w_wr_nxt    = 1'b1;
                w_data_nxt  = hdr_byte(4'(r_grant));
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_cur_valid) begin
                    w_wr_nxt   = 1'b1;
                    w_data_nxt = w_cur_data;
                    if (w_cur_last || (r_cnt == CNT_W'(MAX_MSG_BYTES - 1))) begin
                        // Hitting the byte limit without last cuts the message;
                        // the slot's remaining bytes become a new message.
                        w_state_nxt      = ST_IDLE;
                        w_last_grant_nxt = r_grant;
                        w_cnt_nxt        = '0;
                        if (!w_cur_last) begin
                            w_trunc_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_SLOTS - 1);
            r_cnt        <= '0;
            r_trunc_err  <= 1'b0;
            r_fifo_write <= 1'b0;
            r_fifo_data  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_trunc_err  <= w_trunc_nxt;
            r_fifo_write <= w_wr_nxt;
            r_fifo_data  <= w_data_nxt;
        end
    end

    assign fifo_write   = r_fifo_write;
    assign fifo_data    = r_fifo_data;
    assign grant_active = (r_state != ST_IDLE);
    assign trunc_err    = r_trunc_err;

endmodule

// File: doc/slot_write_arbiter.md
SLOT_WRITE_ARBITER -- requirements
Module: slot_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4, number of requesting slot converters (2..16).
REQ-002 The block SHALL have parameter MAX_MSG_BYTES, default 16, maximum payload bytes per granted message.
REQ-003 The block SHALL have parameter ADDR_W, default 11, FIFO pointer width (FIFO depth 2^ADDR_W).
REQ-004 Port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_SLOTS: per-slot byte valid.
REQ-007 Port req_data, input, 8*NUM_SLOTS: per-slot byte; slot i uses bits [8i+7:8i].
REQ-008 Port req_last, input, NUM_SLOTS: per-slot final byte of message.
REQ-009 Port req_ready, output, NUM_SLOTS: per-slot byte accepted this cycle (valid & ready).
REQ-010 Port fifo_data, output, 8: byte to shared FIFO.
REQ-011 Port fifo_write, output, 1: FIFO write strobe, one byte per asserted cycle.
REQ-012 Port fifo_addr_in, input, ADDR_W: FIFO write pointer.
REQ-013 Port fifo_addr_out, input, ADDR_W: FIFO read pointer.
REQ-014 Port grant_active, output, 1: a message is in progress.
REQ-015 Port trunc_err, output, 1: sticky, a message hit MAX_MSG_BYTES without req_last.

Function
REQ-016 used = (fifo_addr_in - fifo_addr_out) mod 2^ADDR_W; free = 2^ADDR_W - 1 - used.
REQ-017 States SHALL be IDLE, HEADER, DATA.
REQ-018 IDLE: if any req_valid and free >= MAX_MSG_BYTES+1, grant the first valid slot after last_grant (round robin, wrapping NUM_SLOTS-1 -> 0), latch grant, go to HEADER; else stay.
REQ-019 HEADER: one cycle later fifo_write=1, fifo_data=8'hA0|grant[3:0]; go to DATA.
REQ-020 DATA: req_ready[grant]=req_valid-independent 1, all other req_ready 0; req_ready is combinational from state and grant.
REQ-021 Each DATA handshake SHALL produce fifo_write=1 with that byte on the next cycle (one-cycle registered latency); no handshake -> fifo_write=0.
REQ-022 DATA exits to IDLE after the handshake carrying req_last, or after the MAX_MSG_BYTES-th byte; last_grant <= grant on exit.
REQ-023 Reaching MAX_MSG_BYTES without req_last SHALL set trunc_err; remaining bytes form a later, separate message.
REQ-024 Space is checked only in IDLE; once granted, a message completes regardless of pointer changes.
REQ-025 req_valid dropping mid-message SHALL stall DATA indefinitely, writing nothing.
REQ-026 grant_active=1 in HEADER and DATA; req_ready is all zeros in IDLE and HEADER.

Reset
REQ-027 Reset SHALL force IDLE, fifo_write=0, fifo_data=0, req_ready=0, grant_active=0, trunc_err=0, byte count 0, last_grant=NUM_SLOTS-1 (slot 0 first).
REQ-028 Reset mid-message SHALL abandon the message with no further FIFO writes.

Configuration
REQ-029 With SLOT_ARB_HEADER_EN defined, HEADER state is used as above and the space check requires MAX_MSG_BYTES+1.
REQ-030 Without SLOT_ARB_HEADER_EN, IDLE goes directly to DATA, no header byte is written, and the space check requires MAX_MSG_BYTES.

Structure
REQ-031 State encoding, header constant 8'hA0 and default parameter values SHALL live in shared package slot_arb_pkg.
REQ-032 Round-robin grant selection SHALL be sub-module rr_select (request vector, last_grant in; grant index, found out).

Verification
REQ-033 Slot 1 sends 4 bytes EF BE AD DE, last on DE, FIFO empty -> FIFO receives A1 EF BE AD DE, trunc_err=0.
REQ-034 All 4 slots valid continuously after reset -> headers in order A0 A1 A2 A3 A0.
REQ-035 used = 2047-16 (free 16), header enabled -> no grant; read pointer advances by 1 -> grant next cycle.
REQ-036 Slot 2 sends 20 bytes, last on byte 20 -> message of 16 bytes, trunc_err=1, then second message A2 plus 4 bytes.
REQ-037 Reset asserted after 2 of 4 payload bytes -> fifo_write=0 next cycle, IDLE, next grant goes to slot 0.
REQ-038 Build without SLOT_ARB_HEADER_EN, repeat REQ-033 -> FIFO receives EF BE AD DE only.
